// File: rtl/rect_fill_pkg.sv
// rtl/rect_fill_pkg.sv - shared types and constants for the rectangle fill engine
//
// Purpose: FSM state encoding, default framebuffer geometry and helpers for
// the 8-bit 0b00RRGGBB pixel format consumed by the VGA scan-out.
// Ports: none (package).
// Optional feature macro used by this design: RECT_FILL_CLIP_EN.

package rect_fill_pkg;

  localparam int DEF_RES_X     = 320;
  localparam int DEF_RES_Y     = 240;
  localparam int DEF_MEM_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [1:0] color_r(input logic [7:0] c);
    return c[5:4];
  endfunction

  function automatic logic [1:0] color_g(input logic [7:0] c);
    return c[3:2];
  endfunction

  function automatic logic [1:0] color_b(input logic [7:0] c);
    return c[1:0];
  endfunction

  function automatic logic [7:0] pack_color(input logic [1:0] r, input logic [1:0] g,
                                            input logic [1:0] b);
    return {2'b00, r, g, b};
  endfunction

endpackage

// File: rtl/rect_clip.sv
// rtl/rect_clip.sv - maps a rectangle command onto framebuffer bounds
//
// Purpose: combinational bound computation for one fill command.
//   RECT_FILL_CLIP_EN defined  : ends are clamped to the framebuffer, never rejects.
//   RECT_FILL_CLIP_EN undefined: any overhang rejects the whole command.
// Ports:
//   x0, w  in  X_BITS    left column / width
//   y0, h  in  Y_BITS    top row / height
//   x_end  out X_BITS+1  one past the last column written
//   y_end  out Y_BITS+1  one past the last row written
//   empty  out 1         nothing to write
//   reject out 1         command refused (error)

module rect_clip
  import rect_fill_pkg::*;
#(
  parameter int RES_X  = DEF_RES_X,
  parameter int RES_Y  = DEF_RES_Y,
  parameter int X_BITS = $clog2(RES_X),
  parameter int Y_BITS = $clog2(RES_Y)
) (
  input  logic [X_BITS-1:0] x0,
  input  logic [Y_BITS-1:0] y0,
  input  logic [X_BITS-1:0] w,
  input  logic [Y_BITS-1:0] h,
  output logic [X_BITS:0]   x_end,
  output logic [Y_BITS:0]   y_end,
  output logic              empty,
  output logic              reject
);

  localparam logic [X_BITS:0] RES_X_W = (X_BITS+1)'(RES_X);
  localparam logic [Y_BITS:0] RES_Y_W = (Y_BITS+1)'(RES_Y);

  // One extra bit so an overhanging sum cannot wrap back inside the frame.
  logic [X_BITS:0] x_sum;
  logic [Y_BITS:0] y_sum;

  assign x_sum = {1'b0, x0} + {1'b0, w};
  assign y_sum = {1'b0, y0} + {1'b0, h};

  always_comb begin
    x_end  = x_sum;
    y_end  = y_sum;
    empty  = 1'b0;
    reject = 1'b0;
`ifdef RECT_FILL_CLIP_EN
    x_end  = (x_sum > RES_X_W) ? RES_X_W : x_sum;
    y_end  = (y_sum > RES_Y_W) ? RES_Y_W : y_sum;
    empty  = (w == '0) || (h == '0) ||
             ({1'b0, x0} >= RES_X_W) || ({1'b0, y0} >= RES_Y_W);
    reject = 1'b0;
`else
    empty  = (w == '0) || (h == '0);
    reject = (x_sum > RES_X_W) || (y_sum > RES_Y_W);
`endif
  end

endmodule

// File: rtl/rect_fill_engine.sv
// rtl/rect_fill_engine.sv - rectangle fill engine feeding the framebuffer write port
//
// Purpose: accepts one fill command over a valid/ready handshake and streams
// one pixel write per cycle in row-major order, then pulses done (and err
// when the command was rejected). Optional clipping: RECT_FILL_CLIP_EN.
// Ports:
//   clk, rst            in   clock, asynchronous active-high reset
//   cmd_valid/cmd_ready in/out command handshake
//   cmd_x0/y0/w/h/color in   rectangle and fill value
//   hold                in   write-port stall, freezes the fill
//   busy/done/err       out  status (done and err are one-cycle pulses)
//   mem_addr/din/wen    out  registered framebuffer write port

module rect_fill_engine
  import rect_fill_pkg::*;
#(
  parameter int RES_X      = DEF_RES_X,
  parameter int RES_Y      = DEF_RES_Y,
  parameter int MEM_WIDTH  = DEF_MEM_WIDTH,
  parameter int ADDR_WIDTH = $clog2(RES_X*RES_Y),
  parameter int X_BITS     = $clog2(RES_X),
  parameter int Y_BITS     = $clog2(RES_Y)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [X_BITS-1:0]     cmd_x0,
  input  logic [Y_BITS-1:0]     cmd_y0,
  input  logic [X_BITS-1:0]     cmd_w,
  input  logic [Y_BITS-1:0]     cmd_h,
  input  logic [MEM_WIDTH-1:0]  cmd_color,
  input  logic                  hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [MEM_WIDTH-1:0]  din,
  output logic                  wen
);

  state_t state_q, state_d;

  logic [X_BITS-1:0]     x0_q, x0_d, w_q, w_d, x_q, x_d;
  logic [Y_BITS-1:0]     y0_q, y0_d, h_q, h_d, y_q, y_d;
  logic [MEM_WIDTH-1:0]  color_q, color_d, din_q, din_d;
  logic [ADDR_WIDTH-1:0] row_q, row_d, mem_addr_q, mem_addr_d;
  logic                  last_q, last_d, wen_q, wen_d;
  logic                  done_q, done_d, err_q, err_d;
  logic                  busy_q, busy_d, cmd_ready_q, cmd_ready_d;

  logic [X_BITS:0] x_end;
  logic [Y_BITS:0] y_end;
  logic            clip_empty, clip_reject;
  logic            accept, issue, row_wrap;

  logic [X_BITS-1:0]     cur_x;
  logic [Y_BITS-1:0]     cur_y;
  logic [ADDR_WIDTH-1:0] cur_row;
  logic [X_BITS:0]       x_inc;
  logic [Y_BITS:0]       y_inc;

  rect_clip #(
    .RES_X (RES_X),
    .RES_Y (RES_Y),
    .X_BITS(X_BITS),
    .Y_BITS(Y_BITS)
  ) u_clip (
    .x0    (x0_q),
    .y0    (y0_q),
    .w     (w_q),
    .h     (h_q),
    .x_end (x_end),
    .y_end (y_end),
    .empty (clip_empty),
    .reject(clip_reject)
  );

  assign accept = cmd_valid && cmd_ready_q && (state_q == ST_IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. last_q marks that the write now on the port is the
  // final pixel, so DONE lands on the cycle after it regardless of hold.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SETUP;
      ST_SETUP: state_d = (clip_empty || clip_reject) ? ST_DONE : ST_FILL;
      ST_FILL:  if (last_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Pixel walker. SETUP issues the first pixel straight from the latched
  // origin (the only multiply); FILL steps the stored position and advances
  // the row base by RES_X on each wrap.
  always_comb begin
    x0_d       = x0_q;
    y0_d       = y0_q;
    w_d        = w_q;
    h_d        = h_q;
    color_d    = color_q;
    x_d        = x_q;
    y_d        = y_q;
    row_d      = row_q;
    last_d     = last_q;
    mem_addr_d = mem_addr_q;
    din_d      = din_q;
    wen_d      = 1'b0;

    if (accept) begin
      x0_d    = cmd_x0;
      y0_d    = cmd_y0;
      w_d     = cmd_w;
      h_d     = cmd_h;
      color_d = cmd_color;
    end

    if (state_q == ST_SETUP) begin
      cur_x   = x0_q;
      cur_y   = y0_q;
      cur_row = ADDR_WIDTH'(y0_q) * ADDR_WIDTH'(RES_X);
      din_d   = color_q;
    end else begin
      cur_x   = x_q;
      cur_y   = y_q;
      cur_row = row_q;
    end

    x_inc    = {1'b0, cur_x} + 1'b1;
    y_inc    = {1'b0, cur_y} + 1'b1;
    row_wrap = (x_inc == x_end);

    issue = ((state_q == ST_SETUP) && (state_d == ST_FILL)) ||
            ((state_q == ST_FILL) && !last_q && !hold);

    if (issue) begin
      wen_d      = 1'b1;
      mem_addr_d = cur_row + ADDR_WIDTH'(cur_x);
      last_d     = row_wrap && (y_inc == y_end);
      if (row_wrap) begin
        x_d   = x0_q;
        y_d   = y_inc[Y_BITS-1:0];
        row_d = cur_row + ADDR_WIDTH'(RES_X);
      end else begin
        x_d   = x_inc[X_BITS-1:0];
        y_d   = cur_y;
        row_d = cur_row;
      end
    end
  end

  // Status outputs, registered from the upcoming state.
  always_comb begin
    done_d      = (state_d == ST_DONE);
    err_d       = (state_q == ST_SETUP) && (state_d == ST_DONE) && clip_reject;
    busy_d      = (state_d != ST_IDLE);
    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0_q        <= '0;
      y0_q        <= '0;
      w_q         <= '0;
      h_q         <= '0;
      color_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      row_q       <= '0;
      last_q      <= 1'b0;
      mem_addr_q  <= '0;
      din_q       <= '0;
      wen_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      w_q         <= w_d;
      h_q         <= h_d;
      color_q     <= color_d;
      x_q         <= x_d;
      y_q         <= y_d;
      row_q       <= row_d;
      last_q      <= last_d;
      mem_addr_q  <= mem_addr_d;
      din_q       <= din_d;
      wen_q       <= wen_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_addr  = mem_addr_q;
  assign din       = din_q;
  assign wen       = wen_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// tb/tb_rect_fill_engine.sv - directed table-driven bench for rect_fill_engine

module tb_rect_fill_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [8:0]  cmd_x0 = '0;
  logic [7:0]  cmd_y0 = '0;
  logic [8:0]  cmd_w = '0;
  logic [7:0]  cmd_h = '0;
  logic [7:0]  cmd_color = '0;
  logic        hold = 1'b0;
  logic        busy, done, err, wen;
  logic [16:0] mem_addr;
  logic [7:0]  din;

  rect_fill_engine dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_x0   (cmd_x0),
    .cmd_y0   (cmd_y0),
    .cmd_w    (cmd_w),
    .cmd_h    (cmd_h),
    .cmd_color(cmd_color),
    .hold     (hold),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mem_addr (mem_addr),
    .din      (din),
    .wen      (wen)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x0, y0, w, h, color;
    int n_wr, first_addr, last_addr, exp_err, done_cyc;
  } vec_t;

  vec_t vecs[9];

  int n_vec = 0;
  int n_bad = 0;

  int wr_addr[$];
  int wr_cyc[$];
  int wr_din[$];
  int exp_addr[$];
  int done_list[$];
  int done_cyc, done_err, busy_cnt, ready_after;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Reference walk of the rectangle, written independently as nested loops.
  task automatic build_expected(input int x0, input int y0, input int w, input int h);
    int xe, ye;
    exp_addr.delete();
`ifdef RECT_FILL_CLIP_EN
    xe = (x0 + w > 320) ? 320 : x0 + w;
    ye = (y0 + h > 240) ? 240 : y0 + h;
`else
    if (x0 + w > 320 || y0 + h > 240) return;
    xe = x0 + w;
    ye = y0 + h;
`endif
    for (int y = y0; y < ye; y++)
      for (int x = x0; x < xe; x++)
        exp_addr.push_back(y * 320 + x);
  endtask

  task automatic run_cmd(input int x0, input int y0, input int w, input int h,
                         input int color, input int hold_from, input int hold_len);
    int k;
    wr_addr.delete();
    wr_cyc.delete();
    wr_din.delete();
    done_cyc = -1;
    done_err = -1;
    busy_cnt = 0;
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("ready_wait_timeout", 0, 1);
    cmd_x0    = 9'(x0);
    cmd_y0    = 8'(y0);
    cmd_w     = 9'(w);
    cmd_h     = 8'(h);
    cmd_color = 8'(color);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int c = 1; c <= 1000; c++) begin
      hold = (c >= hold_from) && (c < hold_from + hold_len);
      @(negedge clk);
      if (busy) busy_cnt++;
      if (wen) begin
        wr_addr.push_back(int'(mem_addr));
        wr_cyc.push_back(c);
        wr_din.push_back(int'(din));
      end
      if (done) begin
        done_cyc = c;
        done_err = int'(err);
        break;
      end
      @(posedge clk);
      #1;
    end
    hold = 1'b0;
    if (done_cyc < 0) check("done_timeout", 0, 1);
    @(negedge clk);
    ready_after = int'(cmd_ready);
  endtask

  initial begin
    // hand-computed vectors
    vecs[0] = '{10, 5, 3, 2, 'h30, 6, 1610, 1932, 0, 8};
    vecs[1] = '{0, 0, 0, 7, 'h0F, 0, 0, 0, 0, 2};
`ifdef RECT_FILL_CLIP_EN
    vecs[2] = '{318, 239, 5, 3, 'h03, 2, 76798, 76799, 0, 4};
`else
    vecs[2] = '{318, 239, 5, 3, 'h03, 0, 0, 0, 1, 2};
`endif
    vecs[3] = '{0, 0, 1, 1, 'hFF, 1, 0, 0, 0, 3};
    vecs[4] = '{319, 239, 1, 1, 'h2A, 1, 76799, 76799, 0, 3};
    vecs[5] = '{316, 0, 4, 3, 'h11, 12, 316, 959, 0, 14};
`ifdef RECT_FILL_CLIP_EN
    vecs[6] = '{0, 0, 321, 1, 'h15, 320, 0, 319, 0, 322};
    vecs[7] = '{320, 0, 1, 1, 'h3C, 0, 0, 0, 0, 2};
`else
    vecs[6] = '{0, 0, 321, 1, 'h15, 0, 0, 0, 1, 2};
    vecs[7] = '{320, 0, 1, 1, 'h3C, 0, 0, 0, 1, 2};
`endif
    vecs[8] = '{5, 7, 0, 0, 'h01, 0, 0, 0, 0, 2};

    // reset state
    #1;
    check("rst_wen", int'(wen), 0);
    check("rst_ready", int'(cmd_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_addr_din", int'({mem_addr, din}), 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // table-driven vectors
    for (int i = 0; i < 9; i++) begin
      int bad_din, bad_seq;
      run_cmd(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, vecs[i].color, 0, 0);
      build_expected(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h);
      check($sformatf("v%0d_nwr", i), wr_addr.size(), vecs[i].n_wr);
      check($sformatf("v%0d_done_cyc", i), done_cyc, vecs[i].done_cyc);
      check($sformatf("v%0d_err", i), done_err, vecs[i].exp_err);
      check($sformatf("v%0d_ready_after", i), ready_after, 1);
      if (wr_addr.size() > 0) begin
        check($sformatf("v%0d_first_addr", i), wr_addr[0], vecs[i].first_addr);
        check($sformatf("v%0d_last_addr", i), wr_addr[wr_addr.size()-1], vecs[i].last_addr);
        check($sformatf("v%0d_first_wen_cyc", i), wr_cyc[0], 2);
        check($sformatf("v%0d_last_wen_cyc", i), wr_cyc[wr_cyc.size()-1], vecs[i].n_wr + 1);
        bad_din = 0;
        bad_seq = 0;
        foreach (wr_din[j]) if (wr_din[j] != vecs[i].color) bad_din++;
        foreach (wr_addr[j])
          if (j >= exp_addr.size() || wr_addr[j] != exp_addr[j]) bad_seq++;
        check($sformatf("v%0d_din_bad", i), bad_din, 0);
        check($sformatf("v%0d_seq_bad", i), bad_seq, 0);
      end
    end

    // hold for 4 cycles mid-fill of 4x1 at (0,0): writes in cycles 2,3,8,9
    run_cmd(0, 0, 4, 1, 'h0C, 3, 4);
    check("hold_nwr", wr_addr.size(), 4);
    for (int j = 0; j < 4; j++) begin
      int exp_c;
      exp_c = (j < 2) ? j + 2 : j + 6;
      if (j < wr_addr.size()) begin
        check($sformatf("hold_addr%0d", j), wr_addr[j], j);
        check($sformatf("hold_cyc%0d", j), wr_cyc[j], exp_c);
      end
    end
    check("hold_done_cyc", done_cyc, 10);
    // SETUP + 4 writes + 4 stalled cycles + DONE
    check("hold_busy_cnt", busy_cnt, 10);

    // asynchronous reset in the middle of a 20x20 fill
    @(negedge clk);
    while (!cmd_ready) @(negedge clk);
    cmd_x0 = 9'd0; cmd_y0 = 8'd0; cmd_w = 9'd20; cmd_h = 8'd20; cmd_color = 8'h3F;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("pre_rst_wen", int'(wen), 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_wen", int'(wen), 0);
    check("async_rst_addr_din", int'({mem_addr, din}), 0);
    check("async_rst_flags", int'({busy, done, err, cmd_ready}), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready_before_edge", int'(cmd_ready), 0);
    @(negedge clk);
    check("post_rst_ready", int'(cmd_ready), 1);
    run_cmd(10, 5, 3, 2, 'h30, 0, 0);
    check("post_rst_nwr", wr_addr.size(), 6);
    if (wr_addr.size() == 6) begin
      check("post_rst_first", wr_addr[0], 1610);
      check("post_rst_last", wr_addr[5], 1932);
    end
    check("post_rst_done", done_cyc, 8);

    // back-to-back with cmd_valid held high
    wr_addr.delete();
    wr_cyc.delete();
    done_list.delete();
    @(negedge clk);
    while (!cmd_ready) @(negedge clk);
    cmd_x0 = 9'd0; cmd_y0 = 8'd0; cmd_w = 9'd2; cmd_h = 8'd1; cmd_color = 8'h01;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_x0 = 9'd4; cmd_y0 = 8'd4; cmd_w = 9'd1; cmd_h = 8'd2; cmd_color = 8'h02;
    for (int c = 1; c <= 20; c++) begin
      if (c == 6) cmd_valid = 1'b0;
      @(negedge clk);
      if (wen) begin
        wr_addr.push_back(int'(mem_addr));
        wr_cyc.push_back(c);
      end
      if (done) done_list.push_back(c);
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    check("b2b_nwr", wr_addr.size(), 4);
    check("b2b_ndone", done_list.size(), 2);
    begin
      int ea[4];
      int ec[4];
      ea = '{0, 1, 1284, 1604};
      ec = '{2, 3, 7, 8};
      for (int j = 0; j < 4; j++) begin
        if (j < wr_addr.size()) begin
          check($sformatf("b2b_addr%0d", j), wr_addr[j], ea[j]);
          check($sformatf("b2b_cyc%0d", j), wr_cyc[j], ec[j]);
        end
      end
    end
    if (done_list.size() == 2) begin
      check("b2b_done0", done_list[0], 4);
      check("b2b_done1", done_list[1], 9);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
